mc_maindec: RTL and testbench

//  Multicycle main control FSM; sits directly upstream of the ALU function decoder.

---
 rtl/mc_ctrl_pkg.sv | 36 +++
 rtl/mc_maindec.sv | 151 +++++++++++++++
 tb/tb_mc_maindec.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Multicycle control encodings: FSM state codes, opcodes and aluop values.
// Pure definitions, no logic.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_BNEEX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

endpackage

// File: rtl/mc_maindec.sv
// Multicycle main control FSM: Moore datapath controls per state, 3-5 cycles per instruction.
// Memory phases (FETCH, MEMRD, MEMWR) stall in place until memready; writes are masked during reset.
module mc_maindec
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzext,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       illegal
);

    state_t state_q, state_d;
    logic   pcwrite, beq, bne;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_IWB;
            S_ORIEX:   state_d = S_IWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        immzext  = 1'b0;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        beq      = 1'b0;
        bne      = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                    OP_BNE, OP_ADDI, OP_ORI, OP_J: illegal = 1'b0;
                    default:                       illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                beq     = (state_q == S_BEQEX);
                bne     = (state_q == S_BNEEX);
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immzext = 1'b1;
                aluop   = ALUOP_OR;
            end
            S_IWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        pcen = pcwrite | (beq & zero) | (bne & ~zero);

        // Reset cycle must not commit any architectural update.
        if (reset) begin
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_maindec.sv
// Randomized bench for mc_maindec against an instruction-recipe reference model.
module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset, zero, memready;
    logic [5:0] op;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       immzext, pcen, illegal;

    always #5 clk = ~clk;

    mc_maindec dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .immzext(immzext), .pcsrc(pcsrc), .aluop(aluop),
        .pcen(pcen), .illegal(illegal)
    );

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzext;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcen;
        logic       illegal;
    } ctrl_t;

    typedef enum {P_FETCH, P_DEC, P_ADR, P_MRD, P_MWB, P_MWR, P_REX, P_RWB,
                  P_BEQ, P_BNE, P_AEX, P_OEX, P_IWB, P_JEX} ph_t;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    ph_t  ph;
    ph_t  plan[$];
    logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b000101, 6'b001000, 6'b001101, 6'b000010};

    task automatic chk(input string tag, input ctrl_t got, input ctrl_t exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // The phases an instruction visits after DECODE.
    function automatic void recipe(input logic [5:0] o);
        plan.delete();
        case (o)
            6'b100011: begin plan.push_back(P_ADR); plan.push_back(P_MRD); plan.push_back(P_MWB); end
            6'b101011: begin plan.push_back(P_ADR); plan.push_back(P_MWR); end
            6'b000000: begin plan.push_back(P_REX); plan.push_back(P_RWB); end
            6'b000100: plan.push_back(P_BEQ);
            6'b000101: plan.push_back(P_BNE);
            6'b001000: begin plan.push_back(P_AEX); plan.push_back(P_IWB); end
            6'b001101: begin plan.push_back(P_OEX); plan.push_back(P_IWB); end
            6'b000010: plan.push_back(P_JEX);
            default: ;
        endcase
    endfunction

    function automatic ctrl_t expect_ctrl(input ph_t p, input logic r, input logic [5:0] o,
                                          input logic z, input logic m);
        ctrl_t c = '0;
        case (p)
            P_FETCH: begin c.alusrcb = 2'b01; c.irwrite = m; c.pcen = m; end
            P_DEC:   begin c.alusrcb = 2'b11; c.illegal = !is_legal(o); end
            P_ADR:   begin c.alusrca = 1; c.alusrcb = 2'b10; end
            P_MRD:   c.iord = 1;
            P_MWB:   begin c.memtoreg = 1; c.regwrite = 1; end
            P_MWR:   begin c.iord = 1; c.memwrite = 1; end
            P_REX:   begin c.alusrca = 1; c.aluop = 2'b10; end
            P_RWB:   begin c.regdst = 1; c.regwrite = 1; end
            P_BEQ:   begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z; end
            P_BNE:   begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = !z; end
            P_AEX:   begin c.alusrca = 1; c.alusrcb = 2'b10; end
            P_OEX:   begin c.alusrca = 1; c.alusrcb = 2'b10; c.immzext = 1; c.aluop = 2'b11; end
            P_IWB:   c.regwrite = 1;
            P_JEX:   begin c.pcsrc = 2'b10; c.pcen = 1; end
            default: ;
        endcase
        if (r) begin
            c.irwrite = 0; c.pcen = 0; c.regwrite = 0; c.memwrite = 0; c.illegal = 0;
        end
        return c;
    endfunction

    function automatic void advance(input logic r, input logic [5:0] o, input logic m);
        if (r) begin
            ph = P_FETCH;
            plan.delete();
            return;
        end
        if ((ph == P_FETCH || ph == P_MRD || ph == P_MWR) && !m) return;
        if (ph == P_FETCH) begin
            ph = P_DEC;
            return;
        end
        if (ph == P_DEC) recipe(o);
        ph = (plan.size() > 0) ? plan.pop_front() : P_FETCH;
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic z, input logic m);
        ctrl_t got;
        @(negedge clk);
        reset = r; op = o; zero = z; memready = m;
        #1;
        got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, immzext, pcsrc, aluop, pcen, illegal};
        chk(ph.name(), got, expect_ctrl(ph, r, o, z, m));
        @(posedge clk);
        advance(r, o, m);
    endtask

    logic [5:0] cur_op;
    int         lw_cycles;

    initial begin
        reset = 1; op = '0; zero = 0; memready = 1;
        ph = P_FETCH;
        @(posedge clk);
        step(1, 6'b000000, 0, 1);
        step(1, 6'b000000, 0, 1);

        // lw with two stall cycles in MEMRD: seven cycles end to end.
        lw_cycles = 0;
        step(0, 6'b100011, 0, 1); lw_cycles++;
        while (ph != P_FETCH && lw_cycles < 20) begin
            step(0, 6'b100011, 0, (ph == P_MRD && lw_cycles < 5) ? 1'b0 : 1'b1);
            lw_cycles++;
        end
        vec_cnt++;
        if (lw_cycles != 7) begin
            err_cnt++;
            $display("FAIL lw_latency: got %0d cycles, expected 7", lw_cycles);
        end

        // Branches with both zero polarities.
        for (int i = 0; i < 4; i++) begin
            cur_op = (i < 2) ? 6'b000100 : 6'b000101;
            step(0, cur_op, i[0], 1);
            step(0, cur_op, i[0], 1);
            step(0, cur_op, i[0], 1);
        end

        // ori, illegal op, then sw abandoned by reset while waiting in MEMWR.
        repeat (4) step(0, 6'b001101, 0, 1);
        repeat (2) step(0, 6'b111111, 0, 1);
        step(0, 6'b101011, 0, 1);
        step(0, 6'b101011, 0, 1);
        step(0, 6'b101011, 0, 1);
        step(0, 6'b101011, 0, 0);
        step(1, 6'b101011, 0, 0);
        step(0, 6'b101011, 0, 0);

        // Random traffic; op only changes at an instruction boundary.
        cur_op = legal_ops[0];
        for (int n = 0; n < 3000; n++) begin
            logic r, z, m;
            if (ph == P_FETCH) begin
                if ($urandom_range(0, 5) == 0) cur_op = 6'($urandom);
                else cur_op = legal_ops[$urandom_range(0, 7)];
            end
            r = ($urandom_range(0, 49) == 0);
            z = 1'($urandom);
            m = ($urandom_range(0, 9) < 7);
            step(r, cur_op, z, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
